led_pattern_ctrl: RTL and testbench

Controller that owns the 8 board LEDs and sequences what they display. It selects between four display modes: switch mirror, chase, blink and binary count. Modes are stepped by a mode button. Timed modes advance on an internal prescaled tick. It sits between the board switches/button and the LED pins.

---
 rtl/led_pkg.sv | 7 +
 rtl/led_tick_gen.sv | 21 ++
 rtl/led_pattern_ctrl.sv | 60 ++++++
 tb/tb_led_pattern_ctrl.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// led_pkg: shared mode encoding and pattern seeds for the LED controller
package led_pkg;
    localparam int LED_W = 8;
    typedef enum logic [1:0] {MIRROR, CHASE, BLINK, COUNT} led_mode_t;
    localparam logic [LED_W-1:0] CHASE_SEED = 8'h01;
    localparam logic [LED_W-1:0] COUNT_SEED = 8'h00;
endpackage

// File: rtl/led_tick_gen.sv
// led_tick_gen: prescaler producing a one-cycle display tick every TICK_DIV clocks
module led_tick_gen #(
    parameter int unsigned TICK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    logic [CW-1:0] r_cnt;
    assign tick = (r_cnt == CW'(TICK_DIV - 1));
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (clr || tick)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + CW'(1);
    end
endmodule

// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: sequences the board LEDs through mirror, chase, blink and count modes
module led_pattern_ctrl
    import led_pkg::*;
#(
    parameter int unsigned TICK_DIV = 25_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [LED_W-1:0] sw,
    input  logic             mode_btn,
    output logic [LED_W-1:0] led,
    output logic [1:0]       mode
);
    led_mode_t        r_mode, w_mode_nxt;
    logic [LED_W-1:0] r_pat, w_pat_nxt, r_led, w_led_nxt;
    logic             r_blink_on, w_blink_nxt, r_btn_q, w_adv, w_tick;
    assign w_adv = mode_btn & ~r_btn_q;
    assign led   = r_led;
    assign mode  = r_mode;
    led_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (w_adv),
        .tick (w_tick)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode     <= MIRROR;
            r_pat      <= '0;
            r_blink_on <= 1'b1;
            r_btn_q    <= 1'b0;
            r_led      <= '0;
        end else begin
            r_mode     <= w_mode_nxt;
            r_pat      <= w_pat_nxt;
            r_blink_on <= w_blink_nxt;
            r_btn_q    <= mode_btn;
            r_led      <= w_led_nxt;
        end
    end
    // A mode change reseeds the pattern and discards any tick in the same cycle
    always_comb begin
        w_mode_nxt  = w_adv ? led_mode_t'(r_mode + 2'd1) : r_mode;
        w_pat_nxt   = r_pat;
        w_blink_nxt = r_blink_on;
        if (w_adv) begin
            w_pat_nxt   = (w_mode_nxt == CHASE) ? CHASE_SEED : COUNT_SEED;
            w_blink_nxt = 1'b1;
        end else if (w_tick) begin
            if (r_mode == CHASE)
                w_pat_nxt = sw[0] ? {r_pat[0], r_pat[LED_W-1:1]} : {r_pat[LED_W-2:0], r_pat[LED_W-1]};
            if (r_mode == COUNT)
                w_pat_nxt = r_pat + 8'd1;
            if (r_mode == BLINK)
                w_blink_nxt = ~r_blink_on;
        end
        w_led_nxt = (r_mode == MIRROR) ? sw :
                    (r_mode == BLINK)  ? (r_blink_on ? sw : '0) : r_pat;
    end
endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb_led_pattern_ctrl: directed checks of all modes with TICK_DIV=4
module tb_led_pattern_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] sw;
    logic       mode_btn;
    logic [7:0] led;
    logic [1:0] mode;
    int checks = 0;
    int errors = 0;

    led_pattern_ctrl #(.TICK_DIV(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .sw       (sw),
        .mode_btn (mode_btn),
        .led      (led),
        .mode     (mode)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic press();
        mode_btn = 1'b1;
        step(1);
        mode_btn = 1'b0;
        step(1);
    endtask

    initial begin
        rst = 1'b1; sw = 8'hA5; mode_btn = 1'b0;
        step(1);
        check("rst_led", led, 8'h00);
        check("rst_mode", {6'b0, mode}, 8'h00);
        step(2);
        rst = 1'b0;
        check("rel_led", led, 8'h00);
        check("rel_mode", {6'b0, mode}, 8'h00);
        step(1);
        check("mirror_a5", led, 8'hA5);
        sw = 8'h3C;
        step(1);
        check("mirror_3c", led, 8'h3C);
        sw = 8'hC3;
        step(1);
        check("mirror_c3", led, 8'hC3);
        for (int i = 0; i < 20; i++) begin
            step(1);
            check("mirror_hold", led, 8'hC3);
        end
        check("mirror_mode", {6'b0, mode}, 8'h00);
        // chase left, button held for 10 cycles
        mode_btn = 1'b1; sw = 8'h00;
        step(1);
        check("chase_mode", {6'b0, mode}, 8'h01);
        step(1);
        check("chase_seed", led, 8'h01);
        step(4);
        check("chase_02", led, 8'h02);
        step(4);
        check("chase_04", led, 8'h04);
        mode_btn = 1'b0;
        check("held_no_repeat", {6'b0, mode}, 8'h01);
        step(20);
        check("chase_80", led, 8'h80);
        step(4);
        check("chase_wrap", led, 8'h01);
        sw = 8'h01;
        step(4);
        check("chase_r_80", led, 8'h80);
        step(4);
        check("chase_r_40", led, 8'h40);
        // blink
        mode_btn = 1'b1; sw = 8'hF0;
        step(1);
        mode_btn = 1'b0;
        check("blink_mode", {6'b0, mode}, 8'h02);
        step(1);
        check("blink_on1", led, 8'hF0);
        step(3);
        check("blink_on4", led, 8'hF0);
        step(1);
        check("blink_off1", led, 8'h00);
        step(3);
        check("blink_off4", led, 8'h00);
        step(1);
        check("blink_on_again", led, 8'hF0);
        sw = 8'h0F;
        step(1);
        check("blink_sw_live", led, 8'h0F);
        // count
        mode_btn = 1'b1;
        step(1);
        mode_btn = 1'b0;
        check("count_mode", {6'b0, mode}, 8'h03);
        step(1);
        check("count_00", led, 8'h00);
        step(4);
        check("count_01", led, 8'h01);
        step(4);
        check("count_02", led, 8'h02);
        step(1012);
        check("count_ff", led, 8'hFF);
        step(4);
        check("count_wrap", led, 8'h00);
        step(4);
        check("count_01b", led, 8'h01);
        step(2);
        mode_btn = 1'b1;
        step(1);
        mode_btn = 1'b0;
        check("adv_tick_mode", {6'b0, mode}, 8'h00);
        check("adv_tick_led", led, 8'h01);
        step(1);
        check("adv_tick_mirror", led, 8'h0F);
        press(); press(); press();
        check("recount_mode", {6'b0, mode}, 8'h03);
        check("recount_00", led, 8'h00);
        step(8);
        check("recount_02", led, 8'h02);
        #2 rst = 1'b1;
        #1;
        check("async_rst_led", led, 8'h00);
        check("async_rst_mode", {6'b0, mode}, 8'h00);
        step(1);
        rst = 1'b0;
        step(1);
        check("post_rst_mirror", led, 8'h0F);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
